alu_frame_ctrl: RTL and testbench
=================================

# alu_frame_ctrl

Packet-level controller between `uart_rx` and the `alu`. It collects and validates each 4-byte frame header (opcode, reserved, 16-bit length), then replays the header to the ALU and passes the payload through. Malformed frames are drained and discarded, and stalled frames are aborted on an inter-byte timeout. The ALU therefore only ever sees well-formed frames.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles without `rx_valid_i` before a frame in progress is aborted; must be ≥ 2.
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-low reset.
- `rx_valid_i`  in  1  byte valid from uart_rx.
- `rx_data_i`  in  8  byte from uart_rx.
- `rx_ready_o`  out  1  byte accepted when high with `rx_valid_i`.
- `alu_valid_o`  out  1  byte valid to alu.
- `alu_data_o`  out  8  byte to alu.
- `alu_ready_i`  in  1  alu accepts byte.
- `alu_flush_o`  out  1  one-cycle pulse on timeout abort after the ALU has received bytes; wired to clear the ALU.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `err_o`  out  1  one-cycle error pulse.
- `err_code_o`  out  2  last error: 1 bad opcode, 2 bad length, 3 timeout; held until next error.
- `op_o`  out  8  opcode of last validated frame.
- `len_o`  out  16  length of last validated frame.

## Operation
- Frame layout: byte0 opcode, byte1 reserved, byte2 length[7:0], byte3 length[15:8]. Length counts the whole frame including the header.
- Opcodes: 0x10 add, 0x11 sub, 0x12 mul, 0x13 div, 0xEC echo. Anything else is a bad opcode.
- Length rules:
  - Echo requires len ≥ 4.
  - Arithmetic requires len ≥ 12 and (len−4) mod 4 = 0.
  - Otherwise the frame has a bad length. Bad opcode takes precedence over bad length.
- States:
  - IDLE: `rx_ready_o`=1. An accepted byte is stored as hdr[0] → HDR.
  - HDR: `rx_ready_o`=1. Store hdr[1..3]; after hdr[3] is accepted → CHECK.
  - CHECK (1 cycle, `rx_ready_o`=0): load rem = len−4 (16-bit, saturating at 0 for len < 4).
    - Valid frame: latch `op_o`/`len_o`, then → REPLAY.
    - Invalid frame: pulse `err_o`, set `err_code_o`, then → DRAIN if rem > 0, else → IDLE.
  - REPLAY: `alu_valid_o`=1, `alu_data_o`=hdr[i], `rx_ready_o`=0. Advance i on `alu_ready_i`. After hdr[3] is accepted → PASS if rem > 0, else → IDLE.
  - PASS: combinational pass-through (`alu_valid_o`=`rx_valid_i`, `alu_data_o`=`rx_data_i`, `rx_ready_o`=`alu_ready_i`). Decrement rem per handshake; → IDLE after the handshake that makes rem 0.
  - DRAIN: `rx_ready_o`=1, `alu_valid_o`=0. Decrement rem per accepted byte; → IDLE when rem reaches 0.
- Timeout counter:
  - Cleared in IDLE, CHECK, REPLAY, and on any cycle with `rx_valid_i`=1. Increments otherwise.
  - Reaching `TIMEOUT_CYCLES` in HDR, PASS or DRAIN: pulse `err_o`, set code 3, → IDLE.
  - In PASS, also pulse `alu_flush_o` in the same cycle.

## Timing
- Reset (`reset_i`=0 at a clock edge): state IDLE, counters 0, `err_o`=0, `err_code_o`=0, `op_o`=0, `len_o`=0, `alu_flush_o`=0, `busy_o`=0. Derived outputs: `rx_ready_o`=1, `alu_valid_o`=0.
- Reset mid-frame discards the frame with no error or flush pulse.
- Header-to-ALU latency: first replayed byte is presented 2 cycles after the hdr[3] handshake. Minimum replay length is 4 cycles.
- Pass-through adds zero latency and has no storage. `alu_data_o` is stable while `alu_valid_o` is high and `alu_ready_i` is low (inherited from rx for PASS).
- A byte arriving in the cycle the timeout would fire wins: counter clears, no abort.
- The last DRAIN/PASS byte and the next frame's byte0 cannot be accepted in the same cycle; byte0 is accepted in IDLE, one cycle later at the earliest.
- len = 4 echo: REPLAY → IDLE, no PASS.

## Test plan
- Add frame 10 00 0C 00 + 8 payload bytes, `alu_ready_i`=1 → ALU receives exactly those 12 bytes in order; `op_o`=0x10, `len_o`=12; `err_o` never pulses.
- Opcode 0x55, len 0x0008, then 4 payload bytes → `err_o` pulse with code 1 in CHECK; 4 bytes drained; ALU sees nothing; next valid frame processed normally.
- Add with len 0x000A → code 2; 6 bytes drained. Echo with len 0x0002 → code 2; IDLE directly.
- `TIMEOUT_CYCLES`=16, valid add frame stalls after 3 payload bytes → at the 16th idle cycle `err_o`=1, code 3, `alu_flush_o`=1; state IDLE.
- Random `alu_ready_i` toggling during REPLAY and PASS → no byte lost or duplicated; `rx_ready_o` mirrors `alu_ready_i` in PASS.
- `reset_i` low for 1 cycle mid-PASS → all outputs at reset values next cycle; following frame processed correctly.

Source files
------------

// File: rtl/alu_frame_ctrl.sv
// Purpose  : frame gatekeeper between uart_rx and the alu. It collects a 4-byte header
//            (opcode, reserved, len lo, len hi) and checks it. A good header is replayed to
//            the alu and its payload is passed through. A bad frame is drained without
//            reaching the alu. A frame that stalls mid-way is aborted on an idle timeout.
// Latency  : the first replayed header byte reaches the alu 2 cycles after the last header
//            handshake. Payload pass-through is combinational, with zero latency.
// Backpress: during payload, rx_ready_o follows alu_ready_i. Header collect and drain are
//            always ready. rx_ready_o is low in CHECK and REPLAY.
// Ports    : clk_i/reset_i are the clock and synchronous active-low reset.
//            rx_valid_i/rx_data_i/rx_ready_o form the byte stream from uart_rx.
//            alu_valid_o/alu_data_o/alu_ready_i form the byte stream to the alu.
//            alu_flush_o clears the alu after a payload-phase abort.
//            busy_o is high whenever the block is not idle.
//            err_o is a one-cycle error pulse. err_code_o holds the last error:
//            1 = opcode, 2 = length, 3 = timeout.
//            op_o/len_o hold the header of the last accepted frame.

module alu_frame_ctrl #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        alu_valid_o,
   output logic [7:0]  alu_data_o,
   input  logic        alu_ready_i,
   output logic        alu_flush_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic [7:0]  op_o,
   output logic [15:0] len_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, HDR, CHECK, REPLAY, PASS, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [7:0]    hdr [4];
   logic [1:0]    idx;
   logic [15:0]   rem;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic          timeout;

   logic [15:0]   frame_len;
   logic [15:0]   rem_load;
   logic          is_arith, is_echo, len_ok, frame_ok;
   logic [1:0]    bad_code;

   // Header checks, evaluated while in CHECK.
   assign frame_len = {hdr[3], hdr[2]};
   assign rem_load  = (frame_len >= 16'd4) ? frame_len - 16'd4 : 16'd0;
   assign is_arith  = (hdr[0] >= 8'h10) && (hdr[0] <= 8'h13);
   assign is_echo   = (hdr[0] == 8'hEC);
   // (len - 4) mod 4 == 0 is the same test as len mod 4 == 0.
   assign len_ok    = is_echo ? (frame_len >= 16'd4)
                              : ((frame_len >= 16'd12) && (frame_len[1:0] == 2'b00));
   assign frame_ok  = (is_arith || is_echo) && len_ok;
   assign bad_code  = (is_arith || is_echo) ? 2'd2 : 2'd1;

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (!reset_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      rx_ready_o  = 1'b0;
      alu_valid_o = 1'b0;
      alu_data_o  = 8'h00;
      timeout     = 1'b0;

      // Idle-gap counter. A valid byte always clears it, so a byte that arrives in the
      // cycle the abort would have fired wins.
      if ((state == IDLE) || (state == CHECK) || (state == REPLAY) || rx_valid_i)
         tcnt_nxt = '0;
      else
         tcnt_nxt = tcnt + 1'b1;

      // The abort fires at the edge that ends the TIMEOUT_CYCLES-th consecutive idle cycle.
      if (((state == HDR) || (state == PASS) || (state == DRAIN)) &&
          (tcnt_nxt == TW'(TIMEOUT_CYCLES)))
         timeout = 1'b1;

      case (state)
         IDLE: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) state_nxt = HDR;
         end
         HDR: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i && (idx == 2'd3)) state_nxt = CHECK;
         end
         CHECK: begin
            if (frame_ok)             state_nxt = REPLAY;
            else if (rem_load != '0) state_nxt = DRAIN;
            else                      state_nxt = IDLE;
         end
         REPLAY: begin
            alu_valid_o = 1'b1;
            alu_data_o  = hdr[idx];
            if (alu_ready_i && (idx == 2'd3))
               state_nxt = (rem != '0) ? PASS : IDLE;
         end
         PASS: begin
            alu_valid_o = rx_valid_i;
            alu_data_o  = rx_data_i;
            rx_ready_o  = alu_ready_i;
            if (rx_valid_i && alu_ready_i && (rem == 16'd1)) state_nxt = IDLE;
         end
         DRAIN: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i && (rem == 16'd1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // A timeout only fires with rx_valid_i low, so it never races a handshake.
      if (timeout) state_nxt = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         for (int i = 0; i < 4; i++) hdr[i] <= 8'h00;
         idx         <= 2'd0;
         rem         <= 16'd0;
         tcnt        <= '0;
         err_o       <= 1'b0;
         err_code_o  <= 2'd0;
         alu_flush_o <= 1'b0;
         op_o        <= 8'h00;
         len_o       <= 16'h0000;
      end else begin
         err_o       <= 1'b0;
         alu_flush_o <= 1'b0;
         tcnt        <= tcnt_nxt;
         case (state)
            IDLE: if (rx_valid_i) begin
               hdr[0] <= rx_data_i;
               idx    <= 2'd1;
            end
            HDR: if (rx_valid_i) begin
               hdr[idx] <= rx_data_i;
               idx      <= idx + 2'd1;
            end
            CHECK: begin
               rem <= rem_load;
               idx <= 2'd0;
               if (frame_ok) begin
                  op_o  <= hdr[0];
                  len_o <= frame_len;
               end else begin
                  err_o      <= 1'b1;
                  err_code_o <= bad_code;
               end
            end
            REPLAY: if (alu_ready_i) idx <= idx + 2'd1;
            PASS:   if (rx_valid_i && alu_ready_i) rem <= rem - 16'd1;
            DRAIN:  if (rx_valid_i) rem <= rem - 16'd1;
            default: ;
         endcase
         if (timeout) begin
            err_o       <= 1'b1;
            err_code_o  <= 2'd3;
            // Only PASS has already handed bytes to the alu that now need clearing.
            alu_flush_o <= (state == PASS);
         end
      end
   end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Purpose  : self-checking bench for alu_frame_ctrl. It uses a vector table, hand-written
//            corner sequences and random frames checked against a frame-level model.
// Latency  : n/a (testbench)
// Backpress: alu_ready is either forced or randomised on every cycle.

module tb_alu_frame_ctrl;

   localparam int TO = 16;

   logic        clk;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        alu_valid;
   logic [7:0]  alu_data;
   logic        alu_ready;
   logic        alu_flush;
   logic        busy;
   logic        err;
   logic [1:0]  err_code;
   logic [7:0]  op;
   logic [15:0] len;

   alu_frame_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .reset_i(reset),
      .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
      .alu_valid_o(alu_valid), .alu_data_o(alu_data), .alu_ready_i(alu_ready),
      .alu_flush_o(alu_flush), .busy_o(busy), .err_o(err), .err_code_o(err_code),
      .op_o(op), .len_o(len)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] got_alu[$];
   int         got_err[$];
   int         flush_cnt = 0;
   logic       rdy_rand = 1'b0;
   logic       rdy_force = 1'b1;

   // Frame-level model state.
   logic [7:0]  m_op   = 8'h00;
   logic [15:0] m_len  = 16'h0000;
   logic [1:0]  m_code = 2'd0;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] len;
      int          code;
      int          alu_n;
   } vec_t;
   vec_t vecs[12];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // alu_ready driver: changes just after each rising edge.
   initial begin
      alu_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         alu_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
      end
   end

   // Monitor: records alu handshakes, error pulses and flushes, and checks that stalled
   // alu data holds its value.
   initial begin
      logic       prev_stall;
      logic [7:0] prev_dat;
      prev_stall = 1'b0;
      prev_dat   = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && alu_valid) chk("alu_dat_stable", 32'(alu_data), 32'(prev_dat));
            if (alu_valid && alu_ready) got_alu.push_back(alu_data);
            if (err) got_err.push_back(int'(err_code));
            if (alu_flush) flush_cnt++;
            prev_stall = alu_valid && !alu_ready;
            prev_dat   = alu_data;
         end
      end
   end

   function automatic int ref_code(input logic [7:0] opc, input int ln);
      if (opc == 8'hEC) return (ln >= 4) ? 0 : 2;
      if (opc >= 8'h10 && opc <= 8'h13) return (ln >= 12 && (ln - 4) % 4 == 0) ? 0 : 2;
      return 1;
   endfunction

   // The caller must be aligned to posedge+2.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit done;
      done = 1'b0;
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #2; end
      rx_valid = 1'b1;
      rx_data  = b;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         if (rx_ready) done = 1'b1;
         @(posedge clk); #2;
      end
      rx_valid = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL rx_accept: byte %0h not taken within 400 cycles", b);
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 600 && !ok; t++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL idle_wait: busy still %0b after 600 cycles", busy);
      end
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_err"},       32'(err),       32'd0);
      chk({tag, "_err_code"},  32'(err_code),  32'd0);
      chk({tag, "_op"},        32'(op),        32'd0);
      chk({tag, "_len"},       32'(len),       32'd0);
      chk({tag, "_flush"},     32'(alu_flush), 32'd0);
      chk({tag, "_rx_ready"},  32'(rx_ready),  32'd1);
      chk({tag, "_alu_valid"}, 32'(alu_valid), 32'd0);
   endtask

   task automatic clear_obs();
      got_alu.delete();
      got_err.delete();
      flush_cnt = 0;
   endtask

   task automatic run_frame(input logic [7:0] opc, input logic [15:0] ln,
                            input int exp_code, input int exp_n);
      logic [7:0] bytes[$];
      int npay;
      int ok;
      npay = (ln > 16'd4) ? int'(ln) - 4 : 0;
      bytes = {opc, 8'($urandom_range(0, 255)), ln[7:0], ln[15:8]};
      for (int i = 0; i < npay; i++) bytes.push_back(8'($urandom_range(0, 255)));
      @(posedge clk); #2;
      foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, 3));
      wait_idle();
      if (exp_code == 0) begin
         m_op  = opc;
         m_len = ln;
      end else begin
         m_code = 2'(exp_code);
      end
      chk("alu_count", 32'(got_alu.size()), 32'(exp_n));
      if (exp_n > 0 && got_alu.size() == exp_n) begin
         ok = 1;
         for (int i = 0; i < exp_n; i++) if (got_alu[i] !== bytes[i]) ok = 0;
         chk("alu_bytes_in_order", 32'(ok), 32'd1);
      end
      chk("err_pulses", 32'(got_err.size()), (exp_code != 0) ? 32'd1 : 32'd0);
      if (got_err.size() == 1) chk("err_pulse_code", 32'(got_err[0]), 32'(exp_code));
      chk("err_code_held", 32'(err_code), 32'(m_code));
      chk("op_latched", 32'(op), 32'(m_op));
      chk("len_latched", 32'(len), 32'(m_len));
      chk("no_flush", 32'(flush_cnt), 32'd0);
      clear_obs();
   endtask

   initial begin
      logic [7:0] hdr_b[4];
      logic [7:0] pay_b[3];
      bit seen;
      int ok;

      reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

      //               op     len      code alu bytes
      vecs[0]  = '{8'h10, 16'd12, 0, 12};   // add, 8 payload
      vecs[1]  = '{8'h55, 16'd8,  1, 0};    // bad opcode, 4 drained
      vecs[2]  = '{8'h10, 16'd10, 2, 0};    // add len 10, 6 drained
      vecs[3]  = '{8'hEC, 16'd2,  2, 0};    // echo too short, no drain
      vecs[4]  = '{8'hEC, 16'd4,  0, 4};    // header-only echo
      vecs[5]  = '{8'h13, 16'd16, 0, 16};   // div
      vecs[6]  = '{8'h12, 16'd8,  2, 0};    // mul below 12
      vecs[7]  = '{8'h11, 16'd13, 2, 0};    // sub misaligned
      vecs[8]  = '{8'hEC, 16'd7,  0, 7};    // echo odd length
      vecs[9]  = '{8'h00, 16'd3,  1, 0};    // opcode error wins over length
      vecs[10] = '{8'h11, 16'd12, 0, 12};   // sub minimum
      vecs[11] = '{8'hEC, 16'd0,  2, 0};    // echo len 0

      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check_reset_vals("por");
      @(posedge clk); #2;

      rdy_rand = 1'b1;
      foreach (vecs[i]) run_frame(vecs[i].op, vecs[i].len, vecs[i].code, vecs[i].alu_n);

      // Replay latency, then a payload stall that aborts with a flush.
      rdy_rand = 1'b0; rdy_force = 1'b1;
      @(posedge clk); #2;
      hdr_b[0] = 8'h10; hdr_b[1] = 8'h00; hdr_b[2] = 8'h0C; hdr_b[3] = 8'h00;
      pay_b[0] = 8'h31; pay_b[1] = 8'h32; pay_b[2] = 8'h33;
      for (int i = 0; i < 4; i++) send_byte(hdr_b[i], 0);
      @(negedge clk);
      chk("check_cycle_no_alu_valid", 32'(alu_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("replay_byte", 32'({alu_valid, alu_data}), 32'({1'b1, hdr_b[i]}));
      end
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) send_byte(pay_b[i], 0);
      seen = 1'b0;
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         if (err || alu_flush || !busy) seen = 1'b1;
      end
      chk("pass_no_early_abort", 32'(seen), 32'd0);
      @(negedge clk);
      chk("pass_to_err", 32'(err), 32'd1);
      chk("pass_to_code", 32'(err_code), 32'd3);
      chk("pass_to_flush", 32'(alu_flush), 32'd1);
      chk("pass_to_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("pass_to_pulse_width", 32'({err, alu_flush}), 32'd0);
      m_op = 8'h10; m_len = 16'd12; m_code = 2'd3;
      chk("pass_to_op", 32'(op), 32'(m_op));
      chk("pass_to_len", 32'(len), 32'(m_len));
      chk("pass_to_alu_count", 32'(got_alu.size()), 32'd7);
      if (got_alu.size() == 7) begin
         ok = 1;
         for (int i = 0; i < 4; i++) if (got_alu[i] !== hdr_b[i]) ok = 0;
         for (int i = 0; i < 3; i++) if (got_alu[4+i] !== pay_b[i]) ok = 0;
         chk("pass_to_alu_bytes", 32'(ok), 32'd1);
      end
      chk("pass_to_err_pulses", 32'(got_err.size()), 32'd1);
      clear_obs();
      @(posedge clk); #2;

      // Drain: a byte in the would-fire cycle wins, then a full idle gap aborts.
      send_byte(8'h55, 0); send_byte(8'h00, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
      send_byte(8'hA1, 0);
      send_byte(8'hA2, TO - 1);
      seen = 1'b0;
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         if (err || !busy) seen = 1'b1;
      end
      chk("drain_no_early_abort", 32'(seen), 32'd0);
      @(negedge clk);
      chk("drain_to_err", 32'(err), 32'd1);
      chk("drain_to_code", 32'(err_code), 32'd3);
      chk("drain_to_no_flush", 32'(alu_flush), 32'd0);
      chk("drain_to_idle", 32'(busy), 32'd0);
      m_code = 2'd3;
      chk("drain_err_pulses", 32'(got_err.size()), 32'd2);
      if (got_err.size() == 2) chk("drain_first_code", 32'(got_err[0]), 32'd1);
      chk("drain_alu_silent", 32'(got_alu.size()), 32'd0);
      clear_obs();
      @(posedge clk); #2;

      // In PASS, rx_ready follows alu_ready; then a reset mid-frame.
      for (int i = 0; i < 4; i++) send_byte(hdr_b[i], 0);
      send_byte(8'h41, 0);
      send_byte(8'h42, 0);
      rdy_force = 1'b0;
      @(posedge clk); #2;
      rx_valid = 1'b1; rx_data = 8'hA5;
      @(negedge clk);
      chk("pass_ready_follows_lo", 32'(rx_ready), 32'd0);
      chk("pass_valid_through", 32'({alu_valid, alu_data}), 32'({1'b1, 8'hA5}));
      rdy_force = 1'b1;
      @(posedge clk); #2;
      @(negedge clk);
      chk("pass_ready_follows_hi", 32'(rx_ready), 32'd1);
      @(posedge clk); #2;
      rx_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("mid_pass_rst");
      m_op = 8'h00; m_len = 16'h0000; m_code = 2'd0;
      clear_obs();
      run_frame(8'hEC, 16'd6, 0, 6);

      // Random frames against the frame-level model.
      rdy_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [7:0]  r_op;
         logic [15:0] r_len;
         int          code;
         case ($urandom_range(0, 7))
            0: r_op = 8'h10;
            1: r_op = 8'h11;
            2: r_op = 8'h12;
            3: r_op = 8'h13;
            4: r_op = 8'hEC;
            default: r_op = 8'($urandom_range(0, 255));
         endcase
         r_len = 16'($urandom_range(0, 40));
         code  = ref_code(r_op, int'(r_len));
         run_frame(r_op, r_len, code, (code == 0) ? int'(r_len) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
